// File: rtl/multicycle_control_fsm_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm_if
// Control bundle between the multicycle sequencer and the RV32 datapath.
//   inst       : IR contents fed back to the sequencer
//   zero       : ALU zero flag (same-cycle, combinational)
//   pc_write .. alu_ctrl : datapath enables and mux selects
//   state_dbg, retire, instret, halted : debug / CPI observation view
// Modports:
//   master : the sequencer (consumes inst/zero, drives all controls)
//   slave  : the datapath side (drives inst/zero, consumes controls)
// ----------------------------------------------------------------------------
interface multicycle_control_fsm_if #(
  parameter int INSTRET_W = 32
);
  logic [31:0]          inst;
  logic                 zero;
  logic                 pc_write;
  logic                 iord;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic                 pc_source;
  logic [3:0]           alu_ctrl;
  logic [3:0]           state_dbg;
  logic                 retire;
  logic [INSTRET_W-1:0] instret;
  logic                 halted;

  modport master (
    input  inst, zero,
    output pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl,
           state_dbg, retire, instret, halted
  );

  modport slave (
    output inst, zero,
    input  pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl,
           state_dbg, retire, instret, halted
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
// Main sequencer for the multicycle RV32 datapath. Decodes the IR and drives
// every datapath enable/select plus the 4-bit ALU control, one state per
// cycle. Supports lw, sw, R-type add/sub/and/or, addi and beq; any other
// encoding parks the core in HALT until reset.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : control bundle (master modport), see multicycle_control_fsm_if
// Parameters:
//   INSTRET_W : width of the retired-instruction counter (wraps)
// ----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  multicycle_control_fsm_if.master         bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_BRANCH    = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // R-type legality: only add/sub/and/or with the base funct7 encodings.
  function automatic logic rtype_legal(input logic [6:0] f7, input logic [2:0] f3);
    logic v_ok;
    v_ok = 1'b0;
    if (f7 == 7'b0000000) begin
      v_ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110);
    end else if (f7 == 7'b0100000) begin
      v_ok = (f3 == 3'b000);
    end else begin
      v_ok = 1'b0;
    end
    return v_ok;
  endfunction

  // ALU operation for a (legal) R-type instruction.
  function automatic logic [3:0] rtype_alu(input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] v_ctrl;
    v_ctrl = ALU_ADD;
    case (f3)
      3'b000:  v_ctrl = (f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  v_ctrl = ALU_AND;
      3'b110:  v_ctrl = ALU_OR;
      default: v_ctrl = ALU_ADD;
    endcase
    return v_ctrl;
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic [INSTRET_W-1:0]  r_instret;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_inst_bits;

  assign w_opcode = bus.inst[6:0];
  assign w_funct3 = bus.inst[14:12];
  assign w_funct7 = bus.inst[31:25];
  // Register and immediate fields belong to the datapath, not to sequencing.
  assign w_unused_inst_bits = ^{bus.inst[24:15], bus.inst[11:7]};

  // Raw (pre-reset-gating) Moore decode of the current state.
  logic       w_pc_write;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_pc_source;
  logic [3:0] w_alu_ctrl;
  logic       w_retire;
  logic       w_halted;

  // State register: reset always restarts at FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter, bumped at the end of each retire cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end else begin
      r_instret <= r_instret;
    end
  end

  // Next-state logic; the IR is stable from DECODE onward, so later states
  // may still look at the opcode (MEM_ADDR splits lw/sw on it).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if ((w_opcode == OP_LOAD) && (w_funct3 == 3'b010)) begin
          w_next = S_MEM_ADDR;
        end else if ((w_opcode == OP_STORE) && (w_funct3 == 3'b010)) begin
          w_next = S_MEM_ADDR;
        end else if ((w_opcode == OP_RTYPE) && rtype_legal(w_funct7, w_funct3)) begin
          w_next = S_EXEC_R;
        end else if ((w_opcode == OP_IMM) && (w_funct3 == 3'b000)) begin
          w_next = S_EXEC_I;
        end else if ((w_opcode == OP_BRANCH) && (w_funct3 == 3'b000)) begin
          w_next = S_BRANCH;
        end else begin
          w_next = S_HALT;
        end
      end
      S_MEM_ADDR:  w_next = (w_opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = S_MEM_WB;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = S_FETCH;
      S_EXEC_R:    w_next = S_ALU_WB;
      S_EXEC_I:    w_next = S_ALU_WB;
      S_ALU_WB:    w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_HALT;
    endcase
  end

  // Moore output decode; only BRANCH's pc_write looks at the live zero flag.
  always_comb begin
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_pc_source  = 1'b0;
    w_alu_ctrl   = ALU_ADD;
    w_retire     = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_alu_src_b = 2'b01;
      end
      S_DECODE: begin
        // PC <= PC+4 from ALUOut while the ALU forms the branch target.
        w_pc_write  = 1'b1;
        w_pc_source = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEM_WB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_ctrl  = rtype_alu(w_funct7, w_funct3);
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_ctrl  = ALU_SUB;
        w_pc_source = 1'b1;
        w_pc_write  = bus.zero;
        w_retire    = 1'b1;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_halted = 1'b0;
      end
    endcase
  end

  // While reset is high the datapath sees an idle bus (ALU parked on ADD),
  // so an aborted instruction cannot fire any write in that cycle.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_source  = 1'b0;
    bus.alu_ctrl   = ALU_ADD;
    bus.state_dbg  = 4'd0;
    bus.retire     = 1'b0;
    bus.instret    = '0;
    bus.halted     = 1'b0;
    if (!reset) begin
      bus.pc_write   = w_pc_write;
      bus.iord       = w_iord;
      bus.mem_read   = w_mem_read;
      bus.mem_write  = w_mem_write;
      bus.ir_write   = w_ir_write;
      bus.mem_to_reg = w_mem_to_reg;
      bus.reg_write  = w_reg_write;
      bus.alu_src_a  = w_alu_src_a;
      bus.alu_src_b  = w_alu_src_b;
      bus.pc_source  = w_pc_source;
      bus.alu_ctrl   = w_alu_ctrl;
      bus.state_dbg  = r_state;
      bus.retire     = w_retire;
      bus.instret    = r_instret;
      bus.halted     = w_halted;
    end else begin
      bus.alu_ctrl   = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Randomized instruction stream checked against an instruction-level model:
// each IR word is classified by the ISA rules, expanded into its list of
// control steps, and every cycle's control bundle and retire count compared.
// ----------------------------------------------------------------------------
module tb_multicycle_control_fsm;
  localparam int W = 32;

  // Instruction classes
  localparam int C_LW  = 0;
  localparam int C_SW  = 1;
  localparam int C_R   = 2;
  localparam int C_I   = 3;
  localparam int C_BEQ = 4;
  localparam int C_ILL = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.INSTRET_W(W)) bus();
  multicycle_control_fsm #(.INSTRET_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] model_count = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit layout: pc_write,iord,mem_read,mem_write,ir_write,mem_to_reg,
  //   reg_write,alu_src_a,alu_src_b[1:0],pc_source,alu_ctrl[3:0],state[3:0],retire,halted
  function automatic logic [20:0] obs_vec();
    return {bus.pc_write, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.pc_source, bus.alu_ctrl, bus.state_dbg, bus.retire, bus.halted};
  endfunction

  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    if (op == 7'b0000011 && f3 == 3'b010) return C_LW;
    if (op == 7'b0100011 && f3 == 3'b010) return C_SW;
    if (op == 7'b0110011 && ((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6)) ||
                             (f7 == 7'h20 && f3 == 3'd0))) return C_R;
    if (op == 7'b0010011 && f3 == 3'b000) return C_I;
    if (op == 7'b1100011 && f3 == 3'b000) return C_BEQ;
    return C_ILL;
  endfunction

  function automatic logic [3:0] r_alu(input logic [31:0] w);
    if (w[31:25] == 7'h20) return 4'b0110;  // sub
    if (w[14:12] == 3'd7)  return 4'b0000;  // and
    if (w[14:12] == 3'd6)  return 4'b0001;  // or
    return 4'b0010;                          // add
  endfunction

  // Expected control bundle for one step (step id = architectural state number).
  function automatic logic [20:0] exp_step(input int st, input logic [31:0] w, input logic z);
    logic pcw, iord, mr, mw, irw, m2r, rw, asa, pcs, ret, hlt;
    logic [1:0] asb;
    logic [3:0] ac;
    pcw = 0; iord = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rw = 0; asa = 0;
    pcs = 0; ret = 0; hlt = 0; asb = 2'b00; ac = 4'b0010;
    case (st)
      0:  begin mr = 1; irw = 1; asb = 2'b01; end
      1:  begin pcw = 1; pcs = 1; asb = 2'b10; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin iord = 1; mr = 1; end
      4:  begin m2r = 1; rw = 1; ret = 1; end
      5:  begin iord = 1; mw = 1; ret = 1; end
      6:  begin asa = 1; ac = r_alu(w); end
      7:  begin rw = 1; ret = 1; end
      8:  begin asa = 1; asb = 2'b10; end
      9:  begin asa = 1; ac = 4'b0110; pcs = 1; pcw = z; ret = 1; end
      10: begin hlt = 1; end
      default: ;
    endcase
    return {pcw, iord, mr, mw, irw, m2r, rw, asa, asb, pcs, ac, 4'(st), ret, hlt};
  endfunction

  // Called at posedge+1; samples mid-cycle, then advances to the next posedge+1.
  task automatic cycle_check(input int st, input logic [31:0] w, input string tag);
    logic [20:0] e;
    bus.zero = 1'($urandom_range(0, 1));
    #3;
    e = exp_step(st, w, bus.zero);
    check_eq({tag, "/ctl"}, 64'(obs_vec()), 64'(e));
    check_eq({tag, "/instret"}, 64'(bus.instret), 64'(model_count));
    if (e[1]) model_count = model_count + 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus.zero = 1'b1;
    #3;
    check_eq({tag, "/rst_ctl"}, 64'(obs_vec()), 64'h80);  // only alu_ctrl=0010
    check_eq({tag, "/rst_instret"}, 64'(bus.instret), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_count = '0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 7);
    case (sel)
      0: w[6:0] = 7'b0000011;
      1: w[6:0] = 7'b0100011;
      2, 3: w[6:0] = 7'b0110011;
      4: w[6:0] = 7'b0010011;
      5: w[6:0] = 7'b1100011;
      6: w[6:0] = 7'b1101111;
      default: w = 32'h0;
    endcase
    if ($urandom_range(0, 4) != 0) begin
      if (w[6:0] == 7'b0000011 || w[6:0] == 7'b0100011) w[14:12] = 3'b010;
      else if (w[6:0] == 7'b0110011) begin
        case ($urandom_range(0, 2))
          0: w[14:12] = 3'd0;
          1: w[14:12] = 3'd7;
          default: w[14:12] = 3'd6;
        endcase
      end else if (w[6:0] != 7'b0) w[14:12] = 3'b000;
    end
    if (w[6:0] == 7'b0110011) begin
      case ($urandom_range(0, 5))
        0, 1, 2: w[31:25] = 7'h00;
        3: w[31:25] = 7'h20;
        4: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    logic [31:0] dir [4];
    logic [31:0] w;
    int cls;
    int abort_at;
    int steps[$];
    string tag;

    dir[0] = 32'h01400193;  // addi x3,x0,20
    dir[1] = 32'h0781A403;  // lw x8,120(x3)
    dir[2] = 32'h00000000;  // zero word -> HALT
    dir[3] = 32'h0000A283;  // lw x5,0(x1), aborted in MEM_READ

    reset = 1'b1;
    bus.inst = 32'h0;
    bus.zero = 1'b0;
    @(posedge clk); #1;
    do_reset("init");

    for (int k = 0; k < 120; k++) begin
      w = (k < 4) ? dir[k] : rand_word();
      cls = classify(w);
      case (cls)
        C_LW:    steps = '{0, 1, 2, 3, 4};
        C_SW:    steps = '{0, 1, 2, 5};
        C_R:     steps = '{0, 1, 6, 7};
        C_I:     steps = '{0, 1, 8, 7};
        C_BEQ:   steps = '{0, 1, 9};
        default: steps = '{0, 1, 10};
      endcase
      abort_at = -1;
      if (k == 3) abort_at = 3;
      else if (k >= 4 && $urandom_range(0, 19) == 0) abort_at = $urandom_range(0, steps.size() - 1);
      bus.inst = w;
      tag = $sformatf("i%0d_%08h", k, w);
      for (int s = 0; s < steps.size(); s++) begin
        if (s == abort_at) begin
          do_reset({tag, "/abort"});
          break;
        end
        cycle_check(steps[s], w, $sformatf("%s/s%0d", tag, s));
      end
      // After the directed addi+lw pair, 9 cycles in: two retirements.
      if (k == 1) check_eq("preload_instret", 64'(bus.instret), 64'd2);
      if (cls == C_ILL && abort_at < 0) begin
        for (int j = 0; j < 3; j++) begin
          bus.inst = rand_word();
          cycle_check(10, bus.inst, $sformatf("%s/halt%0d", tag, j));
        end
        do_reset({tag, "/recover"});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
